// File: rtl/controlador_salidas.sv
// Seven-segment output controller: sequential binary-to-BCD conversion behind a
// load/busy/done handshake, then continuous 8-digit multiplexed scanning.
module controlador_salidas #(
  parameter int unsigned WIDTH       = 14,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] dato,
  input  logic [1:0]       modo,
  input  logic             cargar,
  output logic             ocupado,
  output logic             listo,
  output logic [7:0]       an,
  output logic [6:0]       seg
);

  localparam int unsigned NDIG = 5;
  localparam int unsigned BW   = 4 * NDIG;
  localparam int unsigned SW   = $clog2(WIDTH + 1);
  localparam int unsigned RW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CONVERT = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  logic [1:0]       state, state_d;
  logic [WIDTH-1:0] bin, bin_d;
  logic [BW-1:0]    bcd, bcd_d, ajustado;
  logic [1:0]       mode_tmp, mode_tmp_d;
  logic [SW-1:0]    pasos, pasos_d;
  logic [BW-1:0]    disp_bcd, disp_bcd_d;
  logic [1:0]       disp_modo, disp_modo_d;
  logic             ocupado_d, listo_d;
  logic [RW-1:0]    refresco, refresco_d;
  logic [2:0]       idx, idx_d;
  logic [7:0]       an_d;
  logic [6:0]       seg_d;
  logic [3:0]       nib;
  logic             blank;

  function automatic logic [6:0] deco(input logic [3:0] d);
    case (d)
      4'd0:    deco = 7'h40;
      4'd1:    deco = 7'h79;
      4'd2:    deco = 7'h24;
      4'd3:    deco = 7'h30;
      4'd4:    deco = 7'h19;
      4'd5:    deco = 7'h12;
      4'd6:    deco = 7'h02;
      4'd7:    deco = 7'h78;
      4'd8:    deco = 7'h00;
      4'd9:    deco = 7'h10;
      default: deco = 7'h7F;
    endcase
  endfunction

  // Conversion FSM: display register is only written in DONE.
  always_comb begin
    state_d     = state;
    bin_d       = bin;
    bcd_d       = bcd;
    mode_tmp_d  = mode_tmp;
    pasos_d     = pasos;
    disp_bcd_d  = disp_bcd;
    disp_modo_d = disp_modo;
    ocupado_d   = ocupado;
    listo_d     = 1'b0;
    ajustado    = bcd;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) ajustado[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    case (state)
      IDLE: begin
        if (cargar) begin
          bin_d      = dato;
          bcd_d      = '0;
          mode_tmp_d = modo;
          pasos_d    = SW'(WIDTH);
          ocupado_d  = 1'b1;
          state_d    = CONVERT;
        end
      end
      CONVERT: begin
        {bcd_d, bin_d} = {ajustado, bin} << 1;
        pasos_d        = pasos - SW'(1);
        if (pasos == SW'(1)) state_d = DONE;
      end
      DONE: begin
        disp_bcd_d  = bcd;
        disp_modo_d = mode_tmp;
        listo_d     = 1'b1;
        ocupado_d   = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Digit selection with leading-zero blanking; digit 7 carries the mode.
  always_comb begin
    nib   = 4'd0;
    blank = 1'b1;
    case (idx)
      3'd0: begin nib = disp_bcd[3:0];   blank = 1'b0; end
      3'd1: begin nib = disp_bcd[7:4];   blank = (disp_bcd[BW-1:4]  == '0); end
      3'd2: begin nib = disp_bcd[11:8];  blank = (disp_bcd[BW-1:8]  == '0); end
      3'd3: begin nib = disp_bcd[15:12]; blank = (disp_bcd[BW-1:12] == '0); end
      3'd4: begin nib = disp_bcd[19:16]; blank = (disp_bcd[BW-1:16] == '0); end
      3'd7: begin nib = {2'b00, disp_modo}; blank = 1'b0; end
      default: blank = 1'b1;
    endcase
    seg_d = blank ? 7'h7F : deco(nib);
    an_d  = ~(8'd1 << idx);
    if (refresco == RW'(REFRESH_DIV - 1)) begin
      refresco_d = '0;
      idx_d      = idx + 3'd1;
    end else begin
      refresco_d = refresco + RW'(1);
      idx_d      = idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bin       <= '0;
      bcd       <= '0;
      mode_tmp  <= '0;
      pasos     <= '0;
      disp_bcd  <= '0;
      disp_modo <= '0;
      ocupado   <= 1'b0;
      listo     <= 1'b0;
      refresco  <= '0;
      idx       <= '0;
      an        <= 8'hFF;
      seg       <= 7'h7F;
    end else begin
      state     <= state_d;
      bin       <= bin_d;
      bcd       <= bcd_d;
      mode_tmp  <= mode_tmp_d;
      pasos     <= pasos_d;
      disp_bcd  <= disp_bcd_d;
      disp_modo <= disp_modo_d;
      ocupado   <= ocupado_d;
      listo     <= listo_d;
      refresco  <= refresco_d;
      idx       <= idx_d;
      an        <= an_d;
      seg       <= seg_d;
    end
  end

endmodule

// File: tb/tb_controlador_salidas.sv
// Self-checking bench for controlador_salidas against a decimal-arithmetic display model.
module tb_controlador_salidas;

  localparam int unsigned WIDTH = 14;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] dato = '0;
  logic [1:0]       modo = '0;
  logic             cargar = 1'b0;
  logic             ocupado, listo;
  logic [7:0]       an;
  logic [6:0]       seg;

  int vectors = 0;
  int miscompares = 0;

  controlador_salidas #(.WIDTH(WIDTH), .REFRESH_DIV(4)) dut (
    .clk(clk), .rst(rst), .dato(dato), .modo(modo), .cargar(cargar),
    .ocupado(ocupado), .listo(listo), .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] code7(input int d);
    case (d)
      0: return 7'h40; 1: return 7'h79; 2: return 7'h24; 3: return 7'h30;
      4: return 7'h19; 5: return 7'h12; 6: return 7'h02; 7: return 7'h78;
      8: return 7'h00; 9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Expected segments for digit position pos showing value v and mode m.
  function automatic logic [6:0] exp_seg(input int v, input int m, input int pos);
    int pw = 1;
    for (int i = 0; i < pos; i++) pw = pw * 10;
    if (pos == 7) return code7(m);
    if (pos == 5 || pos == 6) return 7'h7F;
    if (pos > 0 && v < pw) return 7'h7F;
    return code7((v / pw) % 10);
  endfunction

  function automatic int an_pos(input logic [7:0] a);
    logic [7:0] oh;
    for (int p = 0; p < 8; p++) begin
      oh = 8'd1 << p;
      if (a === ~oh) return p;
    end
    return -1;
  endfunction

  task automatic load(input int v, input int m);
    @(negedge clk);
    dato = WIDTH'(v);
    modo = 2'(m);
    cargar = 1'b1;
    @(negedge clk);
    cargar = 1'b0;
  endtask

  task automatic test_reset();
    int pos;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (an !== 8'hFF || seg !== 7'h7F || ocupado !== 1'b0 || listo !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_async: an=%h seg=%h ocupado=%b listo=%b, required an=ff seg=7f ocupado=0 listo=0",
               an, seg, ocupado, listo);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 36; c++) begin
      @(negedge clk);
      pos = an_pos(an);
      vectors++;
      if (pos < 0 || seg !== exp_seg(0, 0, pos) || ocupado !== 1'b0 || listo !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_scan: an=%h seg=%h, required one-hot-low an and seg=%h",
                 an, seg, (pos < 0) ? 7'h7F : exp_seg(0, 0, pos));
      end
    end
  endtask

  task automatic test_basic_load();
    int pos;
    int pulses = 0;
    load(12345, 2);
    vectors++;
    if (ocupado !== 1'b1 || listo !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_load_edge: ocupado=%b listo=%b, required 1 0", ocupado, listo);
    end
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      vectors++;
      if (ocupado !== (j < 15) || listo !== (j == 15)) begin
        miscompares++;
        $display("FAIL basic_handshake: edge %0d ocupado=%b listo=%b, required %b %b",
                 j, ocupado, listo, (j < 15), (j == 15));
      end
      if (listo === 1'b1) pulses++;
    end
    vectors++;
    if (pulses != 1) begin
      miscompares++;
      $display("FAIL basic_pulses: got %0d listo pulses, required 1", pulses);
    end
    for (int c = 0; c < 36; c++) begin
      @(negedge clk);
      pos = an_pos(an);
      vectors++;
      if (pos < 0 || seg !== exp_seg(12345, 2, pos)) begin
        miscompares++;
        $display("FAIL basic_scan: an=%h seg=%h, required seg=%h", an, seg,
                 (pos < 0) ? 7'h7F : exp_seg(12345, 2, pos));
      end
    end
  endtask

  task automatic test_blanking();
    int pos;
    int vals[2] = '{7, 16383};
    for (int k = 0; k < 2; k++) begin
      load(vals[k], k + 1);
      repeat (16) @(negedge clk);
      for (int c = 0; c < 34; c++) begin
        @(negedge clk);
        pos = an_pos(an);
        vectors++;
        if (pos < 0 || seg !== exp_seg(vals[k], k + 1, pos)) begin
          miscompares++;
          $display("FAIL blanking_%0d: an=%h seg=%h, required seg=%h", vals[k], an, seg,
                   (pos < 0) ? 7'h7F : exp_seg(vals[k], k + 1, pos));
        end
      end
    end
  endtask

  task automatic test_busy_reload();
    int pos;
    int pulses = 0;
    load(500, 1);
    for (int j = 1; j <= 31; j++) begin
      @(negedge clk);
      if (j == 5) begin dato = WIDTH'(99); modo = 2'd3; cargar = 1'b1; end
      if (j == 16) begin
        cargar = 1'b0;
        vectors++;
        if (ocupado !== 1'b1) begin
          miscompares++;
          $display("FAIL busy_retrigger: ocupado=%b at edge 16, required 1", ocupado);
        end
      end
      if (listo === 1'b1) pulses++;
      if (j == 15) begin
        vectors++;
        if (listo !== 1'b1 || ocupado !== 1'b0) begin
          miscompares++;
          $display("FAIL busy_done: listo=%b ocupado=%b at edge 15, required 1 0", listo, ocupado);
        end
      end
      if (j >= 17 && j <= 30) begin
        pos = an_pos(an);
        vectors++;
        if (pos < 0 || seg !== exp_seg(500, 1, pos) || listo !== 1'b0) begin
          miscompares++;
          $display("FAIL busy_display: an=%h seg=%h listo=%b, required seg=%h listo=0", an, seg, listo,
                   (pos < 0) ? 7'h7F : exp_seg(500, 1, pos));
        end
      end
    end
    vectors++;
    if (pulses != 2 || listo !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_pulses: got %0d pulses, listo=%b at edge 31, required 2 and 1", pulses, listo);
    end
    @(negedge clk);
    for (int c = 0; c < 34; c++) begin
      @(negedge clk);
      pos = an_pos(an);
      vectors++;
      if (pos < 0 || seg !== exp_seg(99, 3, pos)) begin
        miscompares++;
        $display("FAIL reload_scan: an=%h seg=%h, required seg=%h", an, seg,
                 (pos < 0) ? 7'h7F : exp_seg(99, 3, pos));
      end
    end
  endtask

  task automatic test_reset_mid_conversion();
    int pos;
    int cyc;
    load(4321, 2);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 34; c++) begin
      @(negedge clk);
      pos = an_pos(an);
      vectors++;
      if (pos < 0 || seg !== exp_seg(0, 0, pos) || listo !== 1'b0 || ocupado !== 1'b0) begin
        miscompares++;
        $display("FAIL abort_display: an=%h seg=%h listo=%b ocupado=%b, required seg=%h listo=0 ocupado=0",
                 an, seg, listo, ocupado, (pos < 0) ? 7'h7F : exp_seg(0, 0, pos));
      end
    end
    load(4321, 2);
    cyc = 0;
    while (listo !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (cyc != 15) begin
      miscompares++;
      $display("FAIL abort_reload_latency: listo after %0d edges, required 15", cyc);
    end
    @(negedge clk);
    for (int c = 0; c < 34; c++) begin
      @(negedge clk);
      pos = an_pos(an);
      vectors++;
      if (pos < 0 || seg !== exp_seg(4321, 2, pos)) begin
        miscompares++;
        $display("FAIL abort_reload_scan: an=%h seg=%h, required seg=%h", an, seg,
                 (pos < 0) ? 7'h7F : exp_seg(4321, 2, pos));
      end
    end
  endtask

  task automatic test_scan_order();
    logic [7:0] prev;
    int hold = 1;
    bit first = 1'b1;
    @(negedge clk);
    prev = an;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      if (an === prev) hold++;
      else begin
        vectors++;
        if (an !== {prev[6:0], prev[7]}) begin
          miscompares++;
          $display("FAIL scan_order: an went %h -> %h, required %h", prev, an, {prev[6:0], prev[7]});
        end
        if (!first) begin
          vectors++;
          if (hold != 4) begin
            miscompares++;
            $display("FAIL scan_hold: an=%h held %0d cycles, required 4", prev, hold);
          end
        end
        first = 1'b0;
        hold = 1;
        prev = an;
      end
    end
  endtask

  task automatic test_random();
    int v, m, pos, cyc;
    for (int k = 0; k < 8; k++) begin
      v = int'($urandom_range(0, 16383));
      m = int'($urandom_range(0, 3));
      load(v, m);
      cyc = 0;
      while (listo !== 1'b1 && cyc < 40) begin
        @(negedge clk);
        cyc++;
      end
      vectors++;
      if (cyc != 15) begin
        miscompares++;
        $display("FAIL random_latency: value %0d listo after %0d edges, required 15", v, cyc);
      end
      @(negedge clk);
      for (int c = 0; c < 34; c++) begin
        @(negedge clk);
        pos = an_pos(an);
        vectors++;
        if (pos < 0 || seg !== exp_seg(v, m, pos)) begin
          miscompares++;
          $display("FAIL random_scan: value %0d mode %0d an=%h seg=%h, required seg=%h", v, m, an, seg,
                   (pos < 0) ? 7'h7F : exp_seg(v, m, pos));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_blanking();
    test_busy_reload();
    test_reset_mid_conversion();
    test_scan_order();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
